// File: rtl/counter_arbiter_if.sv
// Bundle of requester, counter and completion signals for counter_arbiter.
// The arbiter connects on the slave side; requesters/counter/consumer on master.
interface counter_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 5
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ*WIDTH-1:0] req_len;
    logic                  cnt_load;
    logic                  cnt_enable;
    logic [WIDTH-1:0]      cnt_data;
    logic [WIDTH-1:0]      cnt_value;
    logic                  done_valid;
    logic                  done_ready;
    logic [IW-1:0]         done_id;
    logic [WIDTH-1:0]      done_value;

    modport master (
        output req_valid, req_data, req_len, cnt_value, done_ready,
        input  req_ready, cnt_load, cnt_enable, cnt_data,
        input  done_valid, done_id, done_value
    );

    modport slave (
        input  req_valid, req_data, req_len, cnt_value, done_ready,
        output req_ready, cnt_load, cnt_enable, cnt_data,
        output done_valid, done_id, done_value
    );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that sequences one shared load/enable counter.
// One job at a time: load start value, count len increments, report result.
module counter_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    counter_arbiter_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    id_q, id_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [IW-1:0]    last_grant_q, last_grant_d;

    logic             cnt_load_q, cnt_load_d;
    logic             cnt_enable_q, cnt_enable_d;
    logic [WIDTH-1:0] cnt_data_q, cnt_data_d;
    logic             done_valid_q, done_valid_d;
    logic [IW-1:0]    done_id_q, done_id_d;

    logic [WIDTH-1:0] data_arr [NREQ];
    logic [WIDTH-1:0] len_arr  [NREQ];
    logic [IW-1:0]    grant;
    logic             grant_vld;

    // Unpack the flat per-requester job buses
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_arr[i] = bus.req_data[i*WIDTH +: WIDTH];
            len_arr[i]  = bus.req_len[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin search starting just after the last winner
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            logic [IW-1:0] gi;
            gi = IW'((int'(last_grant_q) + k) % NREQ);
            if (!grant_vld && bus.req_valid[gi]) begin
                grant     = gi;
                grant_vld = 1'b1;
            end
        end
    end

    // One-hot accept, only offered while idle and out of reset
    always_comb begin
        bus.req_ready = '0;
        if (!rst && state_q == IDLE && grant_vld) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    // Job sequencing and next registered output values
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        data_d       = data_q;
        len_d        = len_q;
        rem_d        = rem_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    id_d         = grant;
                    data_d       = data_arr[grant];
                    len_d        = len_arr[grant];
                    last_grant_d = grant;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                if (len_q != '0) begin
                    rem_d   = len_q;
                    state_d = RUN;
                end else begin
                    state_d = DONE;
                end
            end
            RUN: begin
                rem_d = rem_q - 1'b1;
                if (rem_q == WIDTH'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.done_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cnt_load_d   = (state_d == LOAD);
        cnt_enable_d = (state_d == RUN);
        cnt_data_d   = (state_d == LOAD) ? data_d : '0;
        done_valid_d = (state_d == DONE);
        done_id_d    = (state_d == DONE) ? id_d : '0;
    end

    // State and output registers; reset drops any job in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            id_q         <= '0;
            data_q       <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            last_grant_q <= IW'(NREQ - 1);
            cnt_load_q   <= 1'b0;
            cnt_enable_q <= 1'b0;
            cnt_data_q   <= '0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            data_q       <= data_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            last_grant_q <= last_grant_d;
            cnt_load_q   <= cnt_load_d;
            cnt_enable_q <= cnt_enable_d;
            cnt_data_q   <= cnt_data_d;
            done_valid_q <= done_valid_d;
            done_id_q    <= done_id_d;
        end
    end

    assign bus.cnt_load   = cnt_load_q;
    assign bus.cnt_enable = cnt_enable_q;
    assign bus.cnt_data   = cnt_data_q;
    assign bus.done_valid = done_valid_q;
    assign bus.done_id    = done_id_q;
    // Counter is idle in DONE, so its live value is the stable result
    assign bus.done_value = done_valid_q ? bus.cnt_value : '0;

endmodule

// File: tb/tb_counter_arbiter.sv
// Testbench for counter_arbiter: vector table plus multi-cycle sequences,
// with a scoreboard queue of expected {id, value} completions.
module tb_counter_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [WIDTH-1:0] cnt_q = '0;

    always #5 clk = ~clk;

    counter_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Behavioural shared counter
    always @(posedge clk) begin
        if (bus.cnt_load)        cnt_q <= bus.cnt_data;
        else if (bus.cnt_enable) cnt_q <= cnt_q + 1'b1;
    end
    assign bus.cnt_value = cnt_q;

    typedef struct {
        int id;
        int val;
    } exp_t;

    typedef struct {
        int id;
        int data;
        int len;
        int exp_val;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_job(input int id, input int data, input int len);
        bus.req_data[id*WIDTH +: WIDTH] = WIDTH'(data);
        bus.req_len[id*WIDTH +: WIDTH]  = WIDTH'(len);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".cnt_load"},   int'(bus.cnt_load),   0);
        chk({tag, ".cnt_enable"}, int'(bus.cnt_enable), 0);
        chk({tag, ".cnt_data"},   int'(bus.cnt_data),   0);
        chk({tag, ".done_valid"}, int'(bus.done_valid), 0);
        chk({tag, ".done_id"},    int'(bus.done_id),    0);
        chk({tag, ".req_ready"},  int'(bus.req_ready),  0);
    endtask

    // Called at a negedge; ends on the accepting posedge
    task automatic wait_grant(input string tag, input int exp_id);
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.req_ready != '0) break;
            @(negedge clk);
        end
        chk({tag, ".grant"}, int'(bus.req_ready), 1 << exp_id);
        @(posedge clk);
    endtask

    // Follow a job from accept to done, then check it against the scoreboard
    task automatic track_done(input string tag, input int len,
                              input logic [NREQ-1:0] keep);
        int loads = 0;
        int ens   = 0;
        int both  = 0;
        int rdy   = 0;
        int k     = 1;
        exp_t e;
        @(negedge clk);
        bus.req_valid = bus.req_valid & keep;
        while (!bus.done_valid && k < 60) begin
            loads += int'(bus.cnt_load);
            ens   += int'(bus.cnt_enable);
            if (bus.cnt_load && bus.cnt_enable) both++;
            if (bus.req_ready != '0) rdy++;
            @(negedge clk);
            k++;
        end
        chk({tag, ".latency"}, k, 2 + len);
        chk({tag, ".loads"}, loads, 1);
        chk({tag, ".enables"}, ens, len);
        chk({tag, ".load_and_en"}, both, 0);
        chk({tag, ".busy_ready"}, rdy, 0);
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".done_id"}, int'(bus.done_id), e.id);
            chk({tag, ".done_value"}, int'(bus.done_value), e.val);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{id: 0, data: 3,  len: 4,  exp_val: 7};
        tbl[1] = '{id: 2, data: 30, len: 5,  exp_val: 3};
        tbl[2] = '{id: 1, data: 9,  len: 0,  exp_val: 9};
        tbl[3] = '{id: 3, data: 31, len: 1,  exp_val: 0};
        tbl[4] = '{id: 0, data: 0,  len: 31, exp_val: 31};
        tbl[5] = '{id: 1, data: 17, len: 31, exp_val: 16};

        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.req_len    = '0;
        bus.done_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("idle");

        // Single-requester jobs from the table
        foreach (tbl[i]) begin
            set_job(tbl[i].id, tbl[i].data, tbl[i].len);
            bus.req_valid = NREQ'(1 << tbl[i].id);
            sb.push_back('{id: tbl[i].id, val: tbl[i].exp_val});
            wait_grant($sformatf("vec%0d", i), tbl[i].id);
            track_done($sformatf("vec%0d", i), tbl[i].len, '0);
        end

        // All requesters held valid: round-robin from a fresh reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < NREQ; r++) set_job(r, 4 * r + 1, 1);
        bus.req_valid = '1;
        for (int j = 0; j < 5; j++) begin
            int w;
            w = j % NREQ;
            sb.push_back('{id: w, val: 4 * w + 2});
            wait_grant($sformatf("rr%0d", j), w);
            track_done($sformatf("rr%0d", j), 1, '1);
        end
        bus.req_valid = '0;

        // Back-pressure on done: result held, no accept until released
        @(negedge clk);
        @(negedge clk);
        bus.done_ready = 1'b0;
        set_job(2, 5, 2);
        bus.req_valid = 4'b0100;
        sb.push_back('{id: 2, val: 7});
        wait_grant("hold", 2);
        track_done("hold", 2, '0);
        set_job(1, 10, 3);
        bus.req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("hold%0d.done_valid", c), int'(bus.done_valid), 1);
            chk($sformatf("hold%0d.done_id", c), int'(bus.done_id), 2);
            chk($sformatf("hold%0d.done_value", c), int'(bus.done_value), 7);
            chk($sformatf("hold%0d.req_ready", c), int'(bus.req_ready), 0);
            @(negedge clk);
        end
        bus.done_ready = 1'b1;
        sb.push_back('{id: 1, val: 13});
        wait_grant("resume", 1);
        track_done("resume", 3, '0);

        // Reset in the middle of a long job drops it silently
        @(negedge clk);
        set_job(3, 20, 10);
        bus.req_valid = 4'b1000;
        wait_grant("rst_job", 3);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        chk("rst_job.running", int'(bus.cnt_enable), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("midrun_rst");
        rst = 1'b0;
        set_job(0, 6, 2);
        bus.req_valid = 4'b1001;
        sb.push_back('{id: 0, val: 8});
        wait_grant("after_rst0", 0);
        track_done("after_rst0", 2, 4'b1000);
        sb.push_back('{id: 3, val: 30});
        wait_grant("after_rst3", 3);
        track_done("after_rst3", 10, '0);

        @(negedge clk);
        repeat (3) @(negedge clk);
        chk_quiet("final");
        chk("sb_leftover", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
